pipe_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV32I pipeline.
//  - Drives hold and flush controls for the PC, if_id, id_ex and ex_mem registers.
//  - Resolves load-use hazards, EX-stage jump redirects and data-memory wait states.
//  - Holds a pending redirect until fetch accepts it.
//  - Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/pipe_ctrl_hazard_detect.sv | 18 +
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: sequencer states and
// the bundle of per-stage control strobes with its canned patterns.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_MEMWAIT = 2'd1,
    PC_REDIR   = 2'd2
  } pc_state_e;

  // Bit order matters: the canned patterns below are written against it.
  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;
    logic ex_mem_hold;
    logic redirect_vld;
  } ctrl_t;

  // Nothing moves specially; the pipe advances normally.
  localparam ctrl_t CTRL_NONE     = 7'b000_0000;
  // Data memory stall: every register up to ex_mem keeps its contents.
  localparam ctrl_t CTRL_FREEZE   = 7'b110_1010;
  // Taken jump: squash the two younger instructions and steer the PC.
  localparam ctrl_t CTRL_REDIRECT = 7'b001_0101;
  // Load-use: hold fetch/decode and drop a bubble into EX.
  localparam ctrl_t CTRL_BUBBLE   = 7'b110_0100;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in ID reads the register a load in
// EX is about to write. x0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  output logic       luh
);

  assign luh = ex_load & (ex_rd != 5'd0) &
               ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline. Controls are
// Mealy outputs so a hazard is acted on in the cycle it is seen; state,
// the pending redirect target, performance counters and the memory-timeout
// flag are registered.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_mem_rd_i,
  input  logic             ex_jump_i,
  input  logic [31:0]      ex_jump_addr_i,
  input  logic             pc_ready_i,
  input  logic             mem_busy_i,
  output logic             pc_hold_o,
  output logic             if_id_hold_o,
  output logic             if_id_flush_o,
  output logic             id_ex_hold_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_hold_o,
  output logic             redirect_vld_o,
  output logic [31:0]      redirect_addr_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(TIMEOUT);

  pc_state_e         state;
  pc_state_e         next_state;
  ctrl_t             ctrl;
  logic [31:0]       addr;
  logic              latch_addr;
  logic [31:0]       redir_addr;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              err;
  logic              luh;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  hazard_detect u_hazard (
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .rs1_used (id_rs1_used_i),
    .rs2_used (id_rs2_used_i),
    .ex_rd    (ex_rd_i),
    .ex_load  (ex_mem_rd_i),
    .luh      (luh)
  );

  // Consecutive-busy run length, clamped at the timeout threshold.
  always_comb begin
    if (wait_cnt == TMO) begin
      wait_inc = wait_cnt;
    end else begin
      wait_inc = wait_cnt + WAIT_W'(1);
    end
  end

  // Per-cycle control decode and next state; all controls forced low in reset.
  always_comb begin
    ctrl       = CTRL_NONE;
    addr       = 32'h0000_0000;
    latch_addr = 1'b0;
    next_state = state;
    if (!rst) begin
      next_state = PC_RUN;
    end else begin
      case (state)
        PC_REDIR: begin
          if (mem_busy_i) begin
            // EX is frozen, so the redirect simply waits; no new jump can arrive.
            ctrl       = CTRL_FREEZE;
            next_state = PC_REDIR;
          end else begin
            ctrl       = CTRL_REDIRECT;
            addr       = redir_addr;
            next_state = pc_ready_i ? PC_RUN : PC_REDIR;
          end
        end
        PC_RUN, PC_MEMWAIT: begin
          // Leaving a memory wait behaves exactly like a normal run cycle.
          if (mem_busy_i) begin
            ctrl       = CTRL_FREEZE;
            next_state = PC_MEMWAIT;
          end else if (ex_jump_i) begin
            // The jump flushes ID, so a load-use bubble for it is moot.
            ctrl       = CTRL_REDIRECT;
            addr       = ex_jump_addr_i;
            latch_addr = ~pc_ready_i;
            next_state = pc_ready_i ? PC_RUN : PC_REDIR;
          end else if (luh) begin
            ctrl       = CTRL_BUBBLE;
            next_state = PC_RUN;
          end else begin
            next_state = PC_RUN;
          end
        end
        default: begin
          next_state = PC_RUN;
        end
      endcase
    end
  end

  // State, redirect latch, busy run length, counters and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PC_RUN;
      redir_addr <= 32'h0000_0000;
      wait_cnt   <= {WAIT_W{1'b0}};
      stall_cnt  <= {CNT_W{1'b0}};
      flush_cnt  <= {CNT_W{1'b0}};
      err        <= 1'b0;
    end else begin
      state <= next_state;
      if (latch_addr) begin
        redir_addr <= ex_jump_addr_i;
      end
      wait_cnt <= mem_busy_i ? wait_inc : {WAIT_W{1'b0}};
      if (mem_busy_i && (wait_inc == TMO)) begin
        err <= 1'b1;
      end
      if (ctrl.pc_hold) begin
        stall_cnt <= sat_inc(stall_cnt);
      end
      if (ctrl.if_id_flush) begin
        flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

  assign pc_hold_o       = ctrl.pc_hold;
  assign if_id_hold_o    = ctrl.if_id_hold;
  assign if_id_flush_o   = ctrl.if_id_flush;
  assign id_ex_hold_o    = ctrl.id_ex_hold;
  assign id_ex_flush_o   = ctrl.id_ex_flush;
  assign ex_mem_hold_o   = ctrl.ex_mem_hold;
  assign redirect_vld_o  = ctrl.redirect_vld;
  assign redirect_addr_o = addr;
  assign stall_cnt_o     = stall_cnt;
  assign flush_cnt_o     = flush_cnt;
  assign err_timeout_o   = err;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run checked
// against a reference model that tracks only "is a redirect pending", the
// busy run length and the counters.
module tb_pipe_ctrl;

  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 8;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_rs1_used, id_rs2_used, ex_mem_rd, ex_jump, pc_ready, mem_busy;
  logic [31:0]      ex_jump_addr;
  logic             pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold;
  logic             redirect_vld;
  logic [31:0]      redirect_addr;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic             err_timeout;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_rs1_used_i(id_rs1_used), .id_rs2_used_i(id_rs2_used),
    .ex_rd_i(ex_rd), .ex_mem_rd_i(ex_mem_rd),
    .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_jump_addr),
    .pc_ready_i(pc_ready), .mem_busy_i(mem_busy),
    .pc_hold_o(pc_hold), .if_id_hold_o(if_id_hold), .if_id_flush_o(if_id_flush),
    .id_ex_hold_o(id_ex_hold), .id_ex_flush_o(id_ex_flush), .ex_mem_hold_o(ex_mem_hold),
    .redirect_vld_o(redirect_vld), .redirect_addr_o(redirect_addr),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .err_timeout_o(err_timeout)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state
  bit          pend;
  logic [31:0] pend_addr;
  int          busy_run;
  int          m_stall;
  int          m_flush;
  bit          m_err;
  logic [6:0]  exp_ctrl;   // {pc_hold,if_id_hold,if_id_flush,id_ex_hold,id_ex_flush,ex_mem_hold,vld}
  logic [31:0] exp_addr;

  function automatic logic [6:0] obs_ctrl();
    return {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_hold, redirect_vld};
  endfunction

  function automatic void model_reset();
    pend = 1'b0; pend_addr = 32'h0; busy_run = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
  endfunction

  function automatic void model_eval();
    bit hz;
    hz = ex_mem_rd && (ex_rd != 5'd0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    exp_addr = 32'h0;
    if (mem_busy)     exp_ctrl = 7'b1101010;
    else if (pend)    begin exp_ctrl = 7'b0010101; exp_addr = pend_addr; end
    else if (ex_jump) begin exp_ctrl = 7'b0010101; exp_addr = ex_jump_addr; end
    else if (hz)      exp_ctrl = 7'b1100100;
    else              exp_ctrl = 7'b0000000;
  endfunction

  function automatic void model_update();
    if (!mem_busy) begin
      if (pend) begin
        if (pc_ready) pend = 1'b0;
      end else if (ex_jump && !pc_ready) begin
        pend = 1'b1; pend_addr = ex_jump_addr;
      end
    end
    busy_run = mem_busy ? busy_run + 1 : 0;
    if (busy_run >= TIMEOUT) m_err = 1'b1;
    if (exp_ctrl[6] && m_stall < CMAX) m_stall++;
    if (exp_ctrl[4] && m_flush < CMAX) m_flush++;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_mem_rd = 1'b0; ex_jump = 1'b0; ex_jump_addr = 32'h0;
    pc_ready = 1'b1; mem_busy = 1'b0;
  endtask

  // Pulse reset inside the low clock phase; no rising edge is crossed.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    ex_jump = 1'b1; ex_jump_addr = 32'hDEAD_BEEF; mem_busy = 1'b1;
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL reset_ctrl got %b want 0", obs_ctrl()); errs++; end
    vecs++; if (redirect_addr !== 32'h0) begin $display("FAIL reset_addr got %h want 0", redirect_addr); errs++; end
    vecs++; if (stall_cnt !== '0 || flush_cnt !== '0) begin $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); errs++; end
    vecs++; if (err_timeout !== 1'b0) begin $display("FAIL reset_err got %b want 0", err_timeout); errs++; end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    idle();
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL reset_idle got %b want 0", obs_ctrl()); errs++; end
    tick();
  endtask

  task automatic test_load_use();
    do_reset(); idle();
    ex_rd = 5'd5; ex_mem_rd = 1'b1;
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    #1;
    vecs++; if (obs_ctrl() !== 7'b1100100) begin $display("FAIL luh_bubble got %b want 1100100", obs_ctrl()); errs++; end
    tick();
    ex_mem_rd = 1'b0; ex_rd = 5'd0;   // bubble now sits in EX
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL luh_after got %b want 0", obs_ctrl()); errs++; end
    vecs++; if (stall_cnt !== 6'd1) begin $display("FAIL luh_stall_cnt got %0d want 1", stall_cnt); errs++; end
    tick();
    ex_rd = 5'd0; ex_mem_rd = 1'b1; id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL luh_x0 got %b want 0", obs_ctrl()); errs++; end
    tick();
  endtask

  task automatic test_jump_ready();
    do_reset(); idle();
    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100; pc_ready = 1'b1;
    ex_rd = 5'd7; ex_mem_rd = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;  // luh discarded
    #1;
    vecs++; if (obs_ctrl() !== 7'b0010101) begin $display("FAIL jump_ctrl got %b want 0010101", obs_ctrl()); errs++; end
    vecs++; if (redirect_addr !== 32'h100) begin $display("FAIL jump_addr got %h want 100", redirect_addr); errs++; end
    tick();
    idle();
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL jump_after got %b want 0", obs_ctrl()); errs++; end
    vecs++; if (flush_cnt !== 6'd1 || stall_cnt !== 6'd0) begin $display("FAIL jump_cnt got %0d/%0d want 1/0", flush_cnt, stall_cnt); errs++; end
    tick();
  endtask

  task automatic test_jump_wait();
    do_reset(); idle();
    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100; pc_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) ex_jump_addr = 32'h0000_0200;
      if (i == 3) pc_ready = 1'b1;
      #1;
      vecs++; if (obs_ctrl() !== 7'b0010101) begin $display("FAIL redir_ctrl[%0d] got %b want 0010101", i, obs_ctrl()); errs++; end
      vecs++; if (redirect_addr !== 32'h100) begin $display("FAIL redir_addr[%0d] got %h want 100", i, redirect_addr); errs++; end
      tick();
    end
    idle();
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL redir_done got %b want 0", obs_ctrl()); errs++; end
    vecs++; if (flush_cnt !== 6'd4) begin $display("FAIL redir_flush_cnt got %0d want 4", flush_cnt); errs++; end
    tick();
  endtask

  task automatic test_mem_busy();
    do_reset(); idle();
    mem_busy = 1'b1; ex_jump = 1'b1; ex_jump_addr = 32'h0000_0300;
    for (int i = 0; i < 10; i++) begin
      #1;
      vecs++; if (obs_ctrl() !== 7'b1101010) begin $display("FAIL busy_ctrl[%0d] got %b want 1101010", i, obs_ctrl()); errs++; end
      vecs++; if (err_timeout !== (i >= TIMEOUT)) begin $display("FAIL busy_err[%0d] got %b want %b", i, err_timeout, (i >= TIMEOUT)); errs++; end
      tick();
    end
    idle();
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL busy_done got %b want 0", obs_ctrl()); errs++; end
    vecs++; if (stall_cnt !== 6'd10 || flush_cnt !== 6'd0) begin $display("FAIL busy_cnt got %0d/%0d want 10/0", stall_cnt, flush_cnt); errs++; end
    tick(); tick();
    #1;
    vecs++; if (err_timeout !== 1'b1) begin $display("FAIL busy_err_sticky got %b want 1", err_timeout); errs++; end
    tick();
  endtask

  task automatic test_reset_in_redir();
    do_reset(); idle();
    ex_jump = 1'b1; ex_jump_addr = 32'h0000_0100; pc_ready = 1'b0;
    tick();
    idle(); pc_ready = 1'b0;
    #1;
    vecs++; if (redirect_vld !== 1'b1) begin $display("FAIL rr_pending got %b want 1", redirect_vld); errs++; end
    rst = 1'b0;
    model_reset();
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL rr_async got %b want 0", obs_ctrl()); errs++; end
    rst = 1'b1;
    #1;
    vecs++; if (obs_ctrl() !== 7'b0) begin $display("FAIL rr_run got %b want 0", obs_ctrl()); errs++; end
    tick();
  endtask

  task automatic test_random();
    do_reset(); idle();
    for (int n = 0; n < 2000; n++) begin
      if (n % 400 == 399) do_reset();
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_rs1_used  = ($urandom_range(0, 3) != 0);
      id_rs2_used  = ($urandom_range(0, 1) != 0);
      ex_mem_rd    = ($urandom_range(0, 2) == 0);
      ex_jump      = ($urandom_range(0, 6) == 0);
      ex_jump_addr = $urandom;
      pc_ready     = ($urandom_range(0, 4) > 1);
      mem_busy     = (n % 200 > 150) ? 1'b1 : ($urandom_range(0, 4) == 0);
      #1;
      model_eval();
      vecs++; if (obs_ctrl() !== exp_ctrl) begin $display("FAIL rnd_ctrl[%0d] got %b want %b", n, obs_ctrl(), exp_ctrl); errs++; end
      if (exp_ctrl[0]) begin
        vecs++; if (redirect_addr !== exp_addr) begin $display("FAIL rnd_addr[%0d] got %h want %h", n, redirect_addr, exp_addr); errs++; end
      end
      vecs++; if (stall_cnt !== m_stall[CNT_W-1:0]) begin $display("FAIL rnd_stall[%0d] got %0d want %0d", n, stall_cnt, m_stall); errs++; end
      vecs++; if (flush_cnt !== m_flush[CNT_W-1:0]) begin $display("FAIL rnd_flush[%0d] got %0d want %0d", n, flush_cnt, m_flush); errs++; end
      vecs++; if (err_timeout !== m_err) begin $display("FAIL rnd_err[%0d] got %b want %b", n, err_timeout, m_err); errs++; end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_jump_ready();
    test_jump_wait();
    test_mem_busy();
    test_reset_in_redir();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
